// File: rtl/tx_mac_feeder_pkg.sv
// Shared constants for the tx_mac feeder: slot count, length width,
// FSM state encodings and the octet-to-word packing rule.
package tx_mac_feeder_pkg;

    localparam int NUM_SLOTS = 2;
    localparam int LEN_W = 11;

    localparam logic [2:0] IN_IDLE  = 3'd0;
    localparam logic [2:0] IN_FILL  = 3'd1;
    localparam logic [2:0] IN_FLUSH = 3'd2;
    localparam logic [2:0] IN_LENW  = 3'd3;
    localparam logic [2:0] IN_DROP  = 3'd4;

    localparam logic [1:0] OUT_IDLE    = 2'd0;
    localparam logic [1:0] OUT_REQ     = 2'd1;
    localparam logic [1:0] OUT_RELEASE = 2'd2;

    function automatic logic [15:0] pack_word(
        input logic [7:0] first,
        input logic [7:0] second,
        input logic       be
    );
        return be ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/tx_mac_feeder_slot_queue.sv
// Commit-order FIFO of slot indices plus per-slot busy flags.
// A slot is busy from commit until its transmit handshake releases it.
module tx_slot_queue
    import tx_mac_feeder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 push_slot,
    input  logic                 pop,
    output logic                 empty,
    output logic                 head_slot,
    output logic [NUM_SLOTS-1:0] busy
);

    logic [1:0]           q;
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;
    logic [NUM_SLOTS-1:0] busy_nxt;

    assign empty     = (count == 2'd0);
    assign head_slot = q[rd_ptr];

    always_comb begin
        busy_nxt = busy;
        if (pop)
            busy_nxt[head_slot] = 1'b0;
        if (push)
            busy_nxt[push_slot] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            busy   <= '0;
        end else begin
            busy <= busy_nxt;
            if (push) begin
                q[wr_ptr] <= push_slot;
                wr_ptr    <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_mac_feeder.sv
// Packs a host octet stream into two DPRAM slots (length word + data)
// and hands committed slots to tx_mac in order via a 4-phase start/done.
module tx_mac_feeder
    import tx_mac_feeder_pkg::*;
#(
    parameter int mac_aw     = 11,
    parameter bit big_endian = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [7:0]        s_data,
    output logic              wr_en,
    output logic [mac_aw-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              start,
    output logic [mac_aw-1:0] buf_start_addr,
    input  logic              done,
    output logic              drop_err,
    output logic [1:0]        slots_busy
);

    localparam int OFF_W      = mac_aw - 1;
    localparam int SLOT_WORDS = 1 << OFF_W;
    localparam int MAX_RAW    = 2 * (SLOT_WORDS - 1);
    localparam int MAX_PKT    = (MAX_RAW < 2047) ? MAX_RAW : 2047;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);

    logic [2:0]       in_st;
    logic [1:0]       out_st;
    logic             cur_slot;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       held;
    logic [1:0]       arm;
    logic             accept;
    logic             push;
    logic             pop;
    logic             q_empty;
    logic             head_slot;

    tx_slot_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_slot (cur_slot),
        .pop       (pop),
        .empty     (q_empty),
        .head_slot (head_slot),
        .busy      (slots_busy)
    );

    // arm delays s_ready until the second edge after reset release
    assign s_ready = (in_st == IN_IDLE && arm[1] && !(&slots_busy))
                   || in_st == IN_FILL || in_st == IN_DROP;
    assign accept   = s_valid && s_ready;
    assign cnt_nxt  = cnt + LEN_W'(1);
    assign word_off = OFF_W'(cnt_nxt[LEN_W-1:1]);
    assign push     = (in_st == IN_LENW);
    assign pop      = (out_st == OUT_RELEASE) && !done;
    assign buf_start_addr = {head_slot, {OFF_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_st    <= IN_IDLE;
            cur_slot <= 1'b0;
            cnt      <= '0;
            held     <= '0;
            arm      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_err <= 1'b0;
        end else begin
            arm      <= {arm[0], 1'b1};
            wr_en    <= 1'b0;
            drop_err <= 1'b0;
            unique case (in_st)
                IN_IDLE: if (accept) begin
                    cur_slot <= slots_busy[0];
                    cnt      <= LEN_W'(1);
                    held     <= s_data;
                    in_st    <= s_last ? IN_FLUSH : IN_FILL;
                end
                IN_FILL: if (accept) begin
                    if (cnt == MAX_LEN) begin
                        drop_err <= 1'b1;
                        in_st    <= s_last ? IN_IDLE : IN_DROP;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt[0]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= {cur_slot, word_off};
                            wr_data <= pack_word(held, s_data, big_endian);
                        end else begin
                            held <= s_data;
                        end
                        if (s_last)
                            in_st <= cnt[0] ? IN_LENW : IN_FLUSH;
                    end
                end
                IN_FLUSH: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {cur_slot, word_off};
                    wr_data <= pack_word(held, 8'h00, big_endian);
                    in_st   <= IN_LENW;
                end
                IN_LENW: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {cur_slot, {OFF_W{1'b0}}};
                    wr_data <= {5'b0, cnt};
                    in_st   <= IN_IDLE;
                end
                IN_DROP: if (accept && s_last)
                    in_st <= IN_IDLE;
                default: in_st <= IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_st <= OUT_IDLE;
            start  <= 1'b0;
        end else begin
            unique case (out_st)
                OUT_IDLE: if (!q_empty && !done) begin
                    start  <= 1'b1;
                    out_st <= OUT_REQ;
                end
                OUT_REQ: if (done) begin
                    start  <= 1'b0;
                    out_st <= OUT_RELEASE;
                end
                OUT_RELEASE: if (!done)
                    out_st <= OUT_IDLE;
                default: out_st <= OUT_IDLE;
            endcase
        end
    end

endmodule
